// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: checker state encoding, default sizes and the full-adder carry helper.
package adder_chk_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CMP  = 2'd2
   } state_t;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_ERR_W = 16;
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction
endpackage

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: one sum bit per cycle from the current operand bits and a registered carry.
module bit_serial_adder
   import adder_chk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic cin,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);
   logic r_c;
   assign sum   = a ^ b ^ r_c;
   assign carry = r_c;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_c <= 1'b0;
      else     r_c <= load ? cin : maj3(a, b, r_c);
endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: captures an adder operand/result vector, recomputes the sum LSB first
// and reports pass/fail with the reference result and a saturating mismatch count.
module adder_result_checker
   import adder_chk_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ERR_W = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [WIDTH-1:0] S,
   input  logic             Cout,
   input  logic             clear,
   output logic             out_valid,
   output logic             pass,
   output logic [WIDTH-1:0] exp_S,
   output logic             exp_Cout,
   output logic [ERR_W-1:0] err_count
);
   localparam int CNT_W = $clog2(WIDTH);
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_s, r_acc, r_exp_s;
   logic             r_cout, r_out_valid, r_pass, r_exp_cout;
   logic [ERR_W-1:0] r_err;
   logic             w_accept, w_last, w_sum, w_carry, w_mismatch;

   assign w_accept   = in_valid && r_state == IDLE;
   assign w_last     = r_cnt == CNT_W'(WIDTH - 1);
   assign w_mismatch = {r_cout, r_s} != {w_carry, r_acc};

   always_comb begin
      w_next = r_state;
      w_next = w_accept ? RUN : w_next;
      w_next = (r_state == RUN && w_last) ? CMP : w_next;
      w_next = (r_state == CMP) ? IDLE : w_next;
   end

   bit_serial_adder u_add (
      .clk   (clk),
      .rst   (rst),
      .load  (w_accept),
      .cin   (Cin),
      .a     (r_a[0]),
      .b     (r_b[0]),
      .sum   (w_sum),
      .carry (w_carry)
   );

   // Operands shift right so bit 0 always feeds the adder; sum bits enter at the MSB.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_s    <= S;
            r_cout <= Cout;
            r_cnt  <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_out_valid <= 1'b0;
         r_pass      <= 1'b0;
         r_exp_s     <= '0;
         r_exp_cout  <= 1'b0;
         r_err       <= '0;
      end else begin
         r_out_valid <= r_state == CMP;
         if (r_state == CMP) begin
            r_pass     <= !w_mismatch;
            r_exp_s    <= r_acc;
            r_exp_cout <= w_carry;
         end
         if (clear) r_err <= '0;
         else if (r_state == CMP && w_mismatch && !(&r_err)) r_err <= r_err + 1'b1;
      end

   assign in_ready  = r_state == IDLE;
   assign out_valid = r_out_valid;
   assign pass      = r_pass;
   assign exp_S     = r_exp_s;
   assign exp_Cout  = r_exp_cout;
   assign err_count = r_err;
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: randomized and directed checks against an arithmetic reference model.
module tb_adder_result_checker;
   localparam int W    = 32;
   localparam int EW   = 8;
   localparam int EMAX = (1 << EW) - 1;
   logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear = 1'b0, Cin = 1'b0, Cout = 1'b0;
   logic [W-1:0]  A = '0, B = '0, S = '0;
   logic          in_ready, out_valid, pass, exp_Cout;
   logic [W-1:0]  exp_S;
   logic [EW-1:0] err_count;
   int            n_chk = 0, n_pass = 0, m_err = 0, pulses = 0;
   int            o_lat, o_err;
   logic          o_pass, o_cout, o_rdy, o_low;
   logic [W-1:0]  o_s;
   bit            o_ok, o_busy_ok;
   logic [W-1:0]  ta [4] = '{32'hFFFF0000, 32'd2017701177, 32'hFFABCEDC, 32'hFFFFFFFF};
   logic [W-1:0]  tb [4] = '{32'h0000FFFF, 32'd1701853, 32'hEF821EDA, 32'h00000000};
   logic [W-1:0]  ts [4] = '{32'h00000000, 32'h785DA516, 32'hEF2DEDB6, 32'h00000000};
   logic          tc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic          tco[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic          tp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [W-1:0]  tes[4] = '{32'h00000000, 32'h785DA516, 32'hEF2DEDB7, 32'h00000000};
   logic          tec[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   int            terr[4] = '{0, 0, 1, 1};

   adder_result_checker #(.WIDTH(W), .ERR_W(EW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout), .clear(clear),
      .out_valid(out_valid), .pass(pass), .exp_S(exp_S), .exp_Cout(exp_Cout),
      .err_count(err_count)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (out_valid) pulses++;

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   endfunction

   function automatic int next_err(input int cur, input bit mism);
      return mism ? ((cur == EMAX) ? EMAX : cur + 1) : cur;
   endfunction

   task automatic gen_vec(output logic [W-1:0] a, output logic [W-1:0] b, output logic [W-1:0] s,
                          output logic ci, output logic co);
      logic [W:0]   e;
      logic [W-1:0] one;
      int           k;
      a   = $urandom;
      b   = $urandom;
      ci  = 1'($urandom_range(0, 1));
      e   = ref_add(a, b, ci);
      s   = e[W-1:0];
      co  = e[W];
      k   = $urandom_range(0, 2);
      one = 1;
      one = one << $urandom_range(0, W - 1);
      if (k == 1) s = s ^ one;
      else if (k == 2) co = ~co;
   endtask

   // Called at a negedge; returns at a negedge after the result pulse with observations latched.
   task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                          input logic ci, input logic co, input bit clr_at_cmp);
      A = a; B = b; S = s; Cin = ci; Cout = co; in_valid = 1'b1;
      o_rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      o_lat = 0; o_ok = 1'b0; o_busy_ok = 1'b1;
      for (int i = 0; i < W + 8; i++) begin
         clear = clr_at_cmp && (o_lat == W);
         @(posedge clk);
         o_lat++;
         @(negedge clk);
         if (out_valid) begin
            o_ok = 1'b1;
            break;
         end
         if (in_ready) o_busy_ok = 1'b0;
      end
      clear  = 1'b0;
      o_pass = pass; o_s = exp_S; o_cout = exp_Cout; o_err = int'(err_count);
      @(negedge clk);
      o_low = !out_valid;
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
      n_chk++; if (pass !== 1'b0) $display("FAIL rst_pass got %b want 0", pass); else n_pass++;
      n_chk++; if (exp_S !== '0 || exp_Cout !== 1'b0) $display("FAIL rst_exp got %h/%b want 0/0", exp_S, exp_Cout); else n_pass++;
      n_chk++; if (err_count !== '0) $display("FAIL rst_err got %0d want 0", err_count); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [W:0] e;
      for (int i = 0; i < 4; i++) begin
         e = ref_add(ta[i], tb[i], tc[i]);
         run_vec(ta[i], tb[i], ts[i], tc[i], tco[i], 1'b0);
         m_err = next_err(m_err, {tco[i], ts[i]} !== e);
         n_chk++; if (o_rdy !== 1'b1) $display("FAIL dir%0d_ready got %b want 1", i, o_rdy); else n_pass++;
         n_chk++; if (!o_ok || o_lat != W + 1) $display("FAIL dir%0d_latency got %0d want %0d", i, o_lat, W + 1); else n_pass++;
         n_chk++; if (o_pass !== tp[i]) $display("FAIL dir%0d_pass got %b want %b", i, o_pass, tp[i]); else n_pass++;
         n_chk++; if (o_s !== tes[i] || o_s !== e[W-1:0]) $display("FAIL dir%0d_exp_S got %h want %h", i, o_s, tes[i]); else n_pass++;
         n_chk++; if (o_cout !== tec[i]) $display("FAIL dir%0d_exp_Cout got %b want %b", i, o_cout, tec[i]); else n_pass++;
         n_chk++; if (o_err != terr[i] || o_err != m_err) $display("FAIL dir%0d_err got %0d want %0d", i, o_err, terr[i]); else n_pass++;
         n_chk++; if (!o_busy_ok || !o_low) $display("FAIL dir%0d_busy_pulse busy_ok=%b low=%b want 1/1", i, o_busy_ok, o_low); else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, s;
      logic         ci, co;
      logic [W:0]   e;
      for (int i = 0; i < 30; i++) begin
         gen_vec(a, b, s, ci, co);
         e = ref_add(a, b, ci);
         run_vec(a, b, s, ci, co, 1'b0);
         m_err = next_err(m_err, {co, s} !== e);
         n_chk++; if (!o_ok || o_lat != W + 1) $display("FAIL rnd%0d_latency got %0d want %0d", i, o_lat, W + 1); else n_pass++;
         n_chk++; if (o_pass !== ({co, s} === e)) $display("FAIL rnd%0d_pass got %b want %b", i, o_pass, {co, s} === e); else n_pass++;
         n_chk++; if ({o_cout, o_s} !== e) $display("FAIL rnd%0d_ref got %b_%h want %b_%h", i, o_cout, o_s, e[W], e[W-1:0]); else n_pass++;
         n_chk++; if (o_err != m_err) $display("FAIL rnd%0d_err got %0d want %0d", i, o_err, m_err); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      logic [W:0]   q_e[$];
      logic         q_p[$];
      logic [W-1:0] va, vb, vs;
      logic         vc, vco, p, acc;
      logic [W:0]   e;
      int           last = -1, n_acc = 0, n_out = 0, cyc = 0;
      bit           gap_ok = 1'b1;
      gen_vec(va, vb, vs, vc, vco);
      A = va; B = vb; S = vs; Cin = vc; Cout = vco; in_valid = 1'b1;
      while (n_out < N && cyc < N * (W + 2) + 60) begin
         acc = 1'b0;
         if (out_valid) begin
            if (q_e.size() == 0) begin
               n_chk++;
               $display("FAIL b2b_extra_out got pulse want none");
            end else begin
               e = q_e.pop_front();
               p = q_p.pop_front();
               m_err = next_err(m_err, !p);
               n_chk++; if ({exp_Cout, exp_S} !== e) $display("FAIL b2b%0d_ref got %b_%h want %b_%h", n_out, exp_Cout, exp_S, e[W], e[W-1:0]); else n_pass++;
               n_chk++; if (pass !== p) $display("FAIL b2b%0d_pass got %b want %b", n_out, pass, p); else n_pass++;
               n_chk++; if (int'(err_count) != m_err) $display("FAIL b2b%0d_err got %0d want %0d", n_out, err_count, m_err); else n_pass++;
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            e = ref_add(va, vb, vc);
            q_e.push_back(e);
            q_p.push_back({vco, vs} === e);
            if (last >= 0 && cyc - last != W + 2) gap_ok = 1'b0;
            last = cyc;
            n_acc++;
            acc = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (n_acc < N) begin
               gen_vec(va, vb, vs, vc, vco);
               A = va; B = vb; S = vs; Cin = vc; Cout = vco;
            end else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_chk++; if (n_acc != N) $display("FAIL b2b_accepts got %0d want %0d", n_acc, N); else n_pass++;
      n_chk++; if (n_out != N) $display("FAIL b2b_results got %0d want %0d", n_out, N); else n_pass++;
      n_chk++; if (!gap_ok) $display("FAIL b2b_spacing got irregular want %0d cycles", W + 2); else n_pass++;
   endtask

   task automatic test_abort();
      logic [W-1:0] a, b, s;
      logic         ci, co;
      logic [W:0]   e;
      int           p0;
      run_vec(32'h1, 32'h1, 32'h3, 1'b0, 1'b0, 1'b0);
      m_err = next_err(m_err, 1'b1);
      n_chk++; if (o_err != m_err || o_err == 0) $display("FAIL abort_pre_err got %0d want %0d", o_err, m_err); else n_pass++;
      A = $urandom; B = $urandom; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      p0  = pulses;
      rst = 1'b1;
      #1;
      m_err = 0;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b0 || pass !== 1'b0) $display("FAIL abort_outs got %b/%b want 0/0", out_valid, pass); else n_pass++;
      n_chk++; if (err_count !== '0 || exp_S !== '0) $display("FAIL abort_state got %0d/%h want 0/0", err_count, exp_S); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 6) @(negedge clk);
      n_chk++; if (pulses != p0) $display("FAIL abort_no_pulse got %0d want %0d", pulses - p0, 0); else n_pass++;
      n_chk++; if (int'(err_count) != m_err) $display("FAIL abort_err got %0d want %0d", err_count, m_err); else n_pass++;
      gen_vec(a, b, s, ci, co);
      e = ref_add(a, b, ci);
      run_vec(a, b, e[W-1:0], ci, e[W], 1'b0);
      n_chk++; if (!o_ok || o_lat != W + 1) $display("FAIL abort_next_latency got %0d want %0d", o_lat, W + 1); else n_pass++;
      n_chk++; if (o_pass !== 1'b1 || {o_cout, o_s} !== e) $display("FAIL abort_next got %b %b_%h want 1 %b_%h", o_pass, o_cout, o_s, e[W], e[W-1:0]); else n_pass++;
   endtask

   task automatic test_saturate_clear();
      logic [W-1:0] a, b;
      logic [W:0]   e;
      int           guard = 0;
      while (m_err < EMAX && guard < EMAX + 4) begin
         a = $urandom; b = $urandom;
         e = ref_add(a, b, 1'b0);
         run_vec(a, b, e[W-1:0] ^ 32'h1, 1'b0, e[W], 1'b0);
         m_err = next_err(m_err, 1'b1);
         guard++;
         n_chk++; if (o_err != m_err) $display("FAIL sat_ramp%0d_err got %0d want %0d", guard, o_err, m_err); else n_pass++;
      end
      a = $urandom; b = $urandom;
      e = ref_add(a, b, 1'b1);
      run_vec(a, b, e[W-1:0], 1'b1, ~e[W], 1'b0);
      m_err = next_err(m_err, 1'b1);
      n_chk++; if (o_err != EMAX || o_err != m_err) $display("FAIL sat_hold_err got %0d want %0d", o_err, EMAX); else n_pass++;
      n_chk++; if (o_pass !== 1'b0) $display("FAIL sat_hold_pass got %b want 0", o_pass); else n_pass++;
      run_vec(a, b, ~e[W-1:0], 1'b1, e[W], 1'b1);
      m_err = 0;
      n_chk++; if (o_err != 0) $display("FAIL clear_vs_mismatch_err got %0d want 0", o_err); else n_pass++;
      n_chk++; if (o_pass !== 1'b0) $display("FAIL clear_vs_mismatch_pass got %b want 0", o_pass); else n_pass++;
      run_vec(a, b, ~e[W-1:0], 1'b1, e[W], 1'b0);
      m_err = next_err(m_err, 1'b1);
      n_chk++; if (o_err != 1 || o_err != m_err) $display("FAIL post_clear_err got %0d want 1", o_err); else n_pass++;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_err = 0;
      n_chk++; if (int'(err_count) != m_err) $display("FAIL idle_clear_err got %0d want 0", err_count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
      test_saturate_clear();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
